axi_bridge: RTL and testbench
=============================

# axi_bridge

Downstream companion of the instruction and data caches: converts their cache-side refill/writeback handshakes (rd_req/rd_rdy/ret_*, wr_req/wr_rdy) into a single AXI master port. One read transaction and one write transaction may be in flight at a time. Data-cache reads take priority over instruction-cache reads. A data read that hits the line of a pending write is held until that write completes.

## Interface
- INST_ID, default 4'd0: ARID used for icache reads.
- DATA_ID, default 4'd1: ARID used for dcache reads; AWID is always DATA_ID.
- clk  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- i_rd_req / d_rd_req  in  1  read request from icache / dcache.
- i_rd_type / d_rd_type  in  3  000 byte, 001 half, 010 word, 100 16-byte line.
- i_rd_addr / d_rd_addr  in  32  read byte address (line-aligned when type=100).
- i_rd_rdy / d_rd_rdy  out  1  request accepted in any cycle with req&&rdy.
- i_ret_valid / d_ret_valid  out  1  returned beat valid.
- i_ret_last / d_ret_last  out  1  final beat.
- ret_data  out  32  shared return data, qualified by the ret_valid signals.
- d_wr_req  in  1  write request; the dcache asserts it only while d_wr_rdy=1.
- d_wr_type  in  3  010 word (uncached), 100 line.
- d_wr_addr  in  32  write byte address.
- d_wr_wstrb  in  4  byte strobe for word writes.
- d_wr_data  in  128  line data, word0 in [31:0]; a word write uses [31:0].
- d_wr_rdy  out  1  write buffer free.
- arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arvalid 1  out: AR channel.
- arready  in  1.
- rid 4, rdata 32, rresp 2, rlast 1, rvalid 1  in: R channel.
- rready  out  1.
- awid 4, awaddr 32, awlen 8, awsize 3, awburst 2, awvalid 1  out: AW channel.
- awready  in  1.
- wid 4, wdata 32, wstrb 4, wlast 1, wvalid 1  out: W channel.
- wready  in  1.
- bid 4, bresp 2, bvalid 1  in: B channel.
- bready  out  1.

## Operation
- Read FSM states: R_IDLE, R_AR, R_DATA.
  - In R_IDLE, d_rd_rdy = !hazard; i_rd_rdy = !(d_rd_req && !hazard). Both are 0 in other states.
  - On acceptance, latch address and type, set the id, then go to R_AR.
  - In R_AR, arvalid=1 with araddr=latched address. arlen=3 for type 100, else 0. arsize=2 for type 100, else type[1:0]. arburst=01 (INCR). When arready=1, go to R_DATA.
  - In R_DATA, rready=1. {i|d}_ret_valid = rvalid && rid==id of that client. ret_last = that qualifier && rlast. ret_data = rdata. rvalid&&rlast returns the FSM to R_IDLE.
- Hazard: the write FSM is not W_IDLE and d_rd_addr[31:4] == buffered waddr[31:4]. It blocks only d_rd_rdy; an icache request may be accepted meanwhile.
- Write FSM states: W_IDLE, W_AW, W_W, W_B.
  - d_wr_rdy = W_IDLE. On d_wr_req, latch the 128-bit data, address, strobe and type, and clear beat counter cnt (2 bits). Go to W_AW.
  - W_AW: awvalid=1, with awlen/awsize/awburst encoded as for reads. awready → W_W.
  - W_W: wvalid=1. wdata = buffer word cnt. wstrb = 4'hf for a line, latched strobe for a word. wlast = (cnt == awlen[1:0]). Each wready increments cnt. wready&&wlast → W_B.
  - W_B: bready=1. bvalid → W_IDLE. bresp is ignored.
- rresp is ignored. wid equals awid.

## Timing
- Reset value of every registered output is 0: arvalid, awvalid, wvalid, cnt, and ids/addresses. rready and bready are decoded from state and are 0 after reset. d_wr_rdy, d_rd_rdy and i_rd_rdy are 1 after reset, since both FSMs come up idle.
- Request accepted in cycle N → arvalid/awvalid first high in cycle N+1. Each stays high until its ready is seen; the payload is stable while valid is high.
- First returned beat appears on ret_* in the same cycle rvalid is seen (combinational pass-through, no added latency).
- Back-to-back: after rlast in cycle M, the next read is accepted in M+1 at the earliest. After bvalid in cycle K, d_wr_rdy is high in K+1.
- Simultaneous i/d read requests: dcache wins, and the icache request stays pending with i_rd_rdy=0.
- A read and a write proceed independently and may overlap when there is no hazard.
- resetn low at any time, including mid-burst: both FSMs go to idle immediately and all valids drop. Partially returned data is discarded, and no ret_valid is produced for it.

## Test plan
- Icache line read at 0x1C00_0000, slave returns 4 beats with 1-cycle gaps → arlen=3, arsize=2, arid=0. i_ret_valid pulses 4 times, i_ret_last on beat 4, and d_ret_valid stays 0.
- Same-cycle i and d line reads → dcache issued first (arid=1). The icache read issues after the dcache rlast, with i_rd_rdy high in the cycle after rlast.
- Dcache writeback at 0x0000_0040 with data 0x4444…_1111, and wready stalled 2 cycles on beat 1 → 4 W beats in order 1111/2222/3333/4444, wstrb=f, wlast only on beat 4, and d_wr_rdy returns the cycle after bvalid.
- Uncached word write to 0xBFAF_8000 with wstrb 0011 → awlen=0, awsize=2, one beat with wstrb=0011 and wlast=1.
- Hazard: a writeback to line 0x80 is pending and a dcache read of 0x84 arrives → d_rd_rdy=0 until the cycle after bvalid. During this window an icache read to 0x200 is accepted.
- resetn pulsed low during beat 2 of a read burst → arvalid, rready and awvalid all drop to 0, no further ret_valid, and both rdy outputs read 1 once resetn is high again.

Source files
------------

// File: rtl/axi_bridge.sv
// axi_bridge: merges icache/dcache refill reads and dcache writebacks onto one AXI master.
// Ports:
//   clk, resetn                         clock, async active-low reset
//   i_rd_* / d_rd_*                     cache read request/accept/return handshakes
//   ret_data                            shared read return data
//   d_wr_*                              dcache write request (buffered line or word)
//   ar*/r*/aw*/w*/b*                    AXI master channels
// One read and one write may be outstanding; dcache reads beat icache reads, and a dcache
// read to the line held in the write buffer waits until that write retires.
module axi_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_rd_req,
    input  logic [2:0]   i_rd_type,
    input  logic [31:0]  i_rd_addr,
    output logic         i_rd_rdy,
    output logic         i_ret_valid,
    output logic         i_ret_last,
    input  logic         d_rd_req,
    input  logic [2:0]   d_rd_type,
    input  logic [31:0]  d_rd_addr,
    output logic         d_rd_rdy,
    output logic         d_ret_valid,
    output logic         d_ret_last,
    output logic [31:0]  ret_data,
    input  logic         d_wr_req,
    input  logic [2:0]   d_wr_type,
    input  logic [31:0]  d_wr_addr,
    input  logic [3:0]   d_wr_wstrb,
    input  logic [127:0] d_wr_data,
    output logic         d_wr_rdy,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,
    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready,
    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic         awvalid,
    input  logic         awready,
    output logic [3:0]   wid,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic [3:0]   bid,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready
);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_W, W_B} wstate_t;

    rstate_t        r_rstate;
    wstate_t        r_wstate;
    logic [3:0]     r_arid;
    logic [31:0]    r_araddr;
    logic [2:0]     r_rtype;
    logic           r_arvalid;
    logic [31:0]    r_awaddr;
    logic [2:0]     r_wtype;
    logic [3:0]     r_wstrb;
    logic [127:0]   r_wbuf;
    logic [1:0]     r_cnt;
    logic           r_awvalid;
    logic           r_wvalid;

    logic w_hazard, w_d_acc, w_i_acc, w_rline, w_wline, w_wlast;
    logic w_unused;

    assign w_unused = ^{rresp, bresp, bid};

    // Line-granular compare against the buffered write; only dcache reads can alias it.
    assign w_hazard = (r_wstate != W_IDLE) && (d_rd_addr[31:4] == r_awaddr[31:4]);
    assign d_rd_rdy = (r_rstate == R_IDLE) && !w_hazard;
    assign i_rd_rdy = (r_rstate == R_IDLE) && !(d_rd_req && !w_hazard);
    assign w_d_acc  = d_rd_req && d_rd_rdy;
    assign w_i_acc  = i_rd_req && i_rd_rdy;

    // Read FSM
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rstate  <= R_IDLE;
            r_arid    <= 4'd0;
            r_araddr  <= 32'd0;
            r_rtype   <= 3'd0;
            r_arvalid <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_d_acc) begin
                        r_arid    <= DATA_ID;
                        r_araddr  <= d_rd_addr;
                        r_rtype   <= d_rd_type;
                        r_arvalid <= 1'b1;
                        r_rstate  <= R_AR;
                    end else if (w_i_acc) begin
                        r_arid    <= INST_ID;
                        r_araddr  <= i_rd_addr;
                        r_rtype   <= i_rd_type;
                        r_arvalid <= 1'b1;
                        r_rstate  <= R_AR;
                    end
                end
                R_AR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid && rlast) r_rstate <= R_IDLE;
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign w_rline     = (r_rtype == 3'b100);
    assign arid        = r_arid;
    assign araddr      = r_araddr;
    assign arlen       = w_rline ? 8'd3 : 8'd0;
    assign arsize      = w_rline ? 3'd2 : {1'b0, r_rtype[1:0]};
    assign arburst     = 2'b01;
    assign arvalid     = r_arvalid;
    assign rready      = (r_rstate == R_DATA);
    // Return path is a straight pass-through, steered by the response id.
    assign i_ret_valid = rready && rvalid && (rid == INST_ID);
    assign d_ret_valid = rready && rvalid && (rid == DATA_ID);
    assign i_ret_last  = i_ret_valid && rlast;
    assign d_ret_last  = d_ret_valid && rlast;
    assign ret_data    = rdata;

    // Write FSM
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wstate  <= W_IDLE;
            r_awaddr  <= 32'd0;
            r_wtype   <= 3'd0;
            r_wstrb   <= 4'd0;
            r_wbuf    <= 128'd0;
            r_cnt     <= 2'd0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (d_wr_req) begin
                        r_awaddr  <= d_wr_addr;
                        r_wtype   <= d_wr_type;
                        r_wstrb   <= d_wr_wstrb;
                        r_wbuf    <= d_wr_data;
                        r_cnt     <= 2'd0;
                        r_awvalid <= 1'b1;
                        r_wstate  <= W_AW;
                    end
                end
                W_AW: begin
                    if (awready) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b1;
                        r_wstate  <= W_W;
                    end
                end
                W_W: begin
                    if (wready) begin
                        r_cnt <= r_cnt + 2'd1;
                        if (w_wlast) begin
                            r_wvalid <= 1'b0;
                            r_wstate <= W_B;
                        end
                    end
                end
                W_B: begin
                    if (bvalid) r_wstate <= W_IDLE;
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    assign w_wline  = (r_wtype == 3'b100);
    assign d_wr_rdy = (r_wstate == W_IDLE);
    assign awid     = DATA_ID;
    assign awaddr   = r_awaddr;
    assign awlen    = w_wline ? 8'd3 : 8'd0;
    assign awsize   = w_wline ? 3'd2 : {1'b0, r_wtype[1:0]};
    assign awburst  = 2'b01;
    assign awvalid  = r_awvalid;
    assign wid      = DATA_ID;
    assign wdata    = r_wbuf[{r_cnt, 5'd0} +: 32];
    assign wstrb    = w_wline ? 4'hf : r_wstrb;
    assign w_wlast  = (r_cnt == awlen[1:0]);
    assign wlast    = w_wlast;
    assign wvalid   = r_wvalid;
    assign bready   = (r_wstate == W_B);

endmodule

// File: tb/tb_axi_bridge.sv
module tb_axi_bridge;

    logic         clk, resetn;
    logic         i_rd_req, i_rd_rdy, i_ret_valid, i_ret_last;
    logic [2:0]   i_rd_type;
    logic [31:0]  i_rd_addr;
    logic         d_rd_req, d_rd_rdy, d_ret_valid, d_ret_last;
    logic [2:0]   d_rd_type;
    logic [31:0]  d_rd_addr;
    logic [31:0]  ret_data;
    logic         d_wr_req, d_wr_rdy;
    logic [2:0]   d_wr_type;
    logic [31:0]  d_wr_addr;
    logic [3:0]   d_wr_wstrb;
    logic [127:0] d_wr_data;
    logic [3:0]   arid, rid, awid, wid, bid;
    logic [31:0]  araddr, rdata, awaddr, wdata;
    logic [7:0]   arlen, awlen;
    logic [2:0]   arsize, awsize;
    logic [1:0]   arburst, rresp, awburst, bresp;
    logic         arvalid, arready, rlast, rvalid, rready;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]   wstrb;

    axi_bridge #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
        .clk(clk), .resetn(resetn),
        .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr),
        .i_rd_rdy(i_rd_rdy), .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last),
        .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr),
        .d_rd_rdy(d_rd_rdy), .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last),
        .ret_data(ret_data),
        .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr),
        .d_wr_wstrb(d_wr_wstrb), .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    typedef struct packed {
        logic        dsel;
        logic [31:0] data;
        logic        last;
    } rexp_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } wexp_t;

    typedef struct packed {
        logic        dsel;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [3:0]  exp_id;
        logic [7:0]  exp_len;
        logic [2:0]  exp_size;
    } rvec_t;

    rexp_t rq[$];
    wexp_t wq[$];
    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Scoreboard: read returns and W beats are compared as the DUT presents them.
    always @(negedge clk) begin
        if (i_ret_valid || d_ret_valid) begin
            if (rq.size() == 0) begin
                n_total++;
                $display("FAIL ret_unexpected: i=%0b d=%0b data=%0h", i_ret_valid, d_ret_valid,
                         ret_data);
            end else begin
                rexp_t e;
                e = rq.pop_front();
                check("ret_d_valid", d_ret_valid, e.dsel);
                check("ret_i_valid", i_ret_valid, !e.dsel);
                check("ret_data", ret_data, e.data);
                check("ret_last", e.dsel ? d_ret_last : i_ret_last, e.last);
            end
        end
        if (wvalid && wready) begin
            if (wq.size() == 0) begin
                n_total++;
                $display("FAIL w_unexpected: wdata=%0h", wdata);
            end else begin
                wexp_t e;
                e = wq.pop_front();
                check("wdata", wdata, e.data);
                check("wstrb", wstrb, e.strb);
                check("wlast", wlast, e.last);
                check("wid", wid, 4'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic ar_hs();
        tick(); arready = 1'b1;
        tick(); arready = 1'b0;
    endtask

    task automatic aw_hs();
        tick(); awready = 1'b1;
        tick(); awready = 1'b0;
    endtask

    // Return n beats with a one-cycle gap after each.
    task automatic rd_beats(input logic [3:0] id, input int n, input logic [31:0] base,
                            input logic dsel);
        for (int b = 0; b < n; b++) begin
            rexp_t e;
            tick();
            rvalid = 1'b1; rid = id; rdata = base + 32'(b); rlast = (b == n - 1);
            e.dsel = dsel; e.data = base + 32'(b); e.last = (b == n - 1);
            rq.push_back(e);
            tick();
            rvalid = 1'b0; rlast = 1'b0;
        end
    endtask

    // One-cycle request pulse; leaves time at the negedge after acceptance.
    task automatic rd_req(input logic dsel, input logic [2:0] typ, input logic [31:0] addr);
        tick();
        if (dsel) begin
            d_rd_req = 1'b1; d_rd_type = typ; d_rd_addr = addr;
        end else begin
            i_rd_req = 1'b1; i_rd_type = typ; i_rd_addr = addr;
        end
        smp();
        check("rd_rdy_accept", dsel ? d_rd_rdy : i_rd_rdy, 1'b1);
        check("arvalid_not_yet", arvalid, 1'b0);
        tick();
        d_rd_req = 1'b0; i_rd_req = 1'b0;
        smp();
    endtask

    task automatic wr_issue(input logic [2:0] typ, input logic [31:0] addr,
                            input logic [3:0] strb, input logic [127:0] data);
        int n;
        n = (typ == 3'b100) ? 4 : 1;
        tick();
        d_wr_req = 1'b1; d_wr_type = typ; d_wr_addr = addr; d_wr_wstrb = strb;
        d_wr_data = data;
        smp();
        check("wr_rdy_idle", d_wr_rdy, 1'b1);
        tick();
        d_wr_req = 1'b0;
        smp();
        check("awvalid", awvalid, 1'b1);
        check("wr_rdy_busy", d_wr_rdy, 1'b0);
        check("awid", awid, 4'd1);
        check("awaddr", awaddr, addr);
        check("awlen", awlen, 8'(n - 1));
        check("awsize", awsize, 3'd2);
        check("awburst", awburst, 2'b01);
        for (int i = 0; i < n; i++) begin
            wexp_t e;
            e.data = data[i*32 +: 32];
            e.strb = (typ == 3'b100) ? 4'hf : strb;
            e.last = (i == n - 1);
            wq.push_back(e);
        end
    endtask

    task automatic w_run(input int stall_beat, input int stall_n, input int nbeats);
        int beat = 0;
        int stall = 0;
        int guard = 0;
        while (beat < nbeats && guard < 40) begin
            tick();
            if (beat == stall_beat && stall < stall_n) begin
                wready = 1'b0; stall++;
            end else begin
                wready = 1'b1;
            end
            smp();
            if (wvalid && wready) beat++;
            guard++;
        end
        tick(); wready = 1'b0;
        check("w_beats", beat, nbeats);
    endtask

    task automatic b_phase(input logic chk_hz);
        smp();
        check("bready", bready, 1'b1);
        check("wvalid_done", wvalid, 1'b0);
        tick(); bvalid = 1'b1;
        smp();
        check("wr_rdy_in_b", d_wr_rdy, 1'b0);
        if (chk_hz) check("hazard_in_b", d_rd_rdy, 1'b0);
        tick(); bvalid = 1'b0;
        smp();
        check("wr_rdy_after_b", d_wr_rdy, 1'b1);
        check("bready_off", bready, 1'b0);
        if (chk_hz) check("hazard_release", d_rd_rdy, 1'b1);
    endtask

    rvec_t vecs[5];

    initial begin
        vecs[0] = '{dsel: 1'b0, typ: 3'b100, addr: 32'h1C00_0000, exp_id: 4'd0,
                    exp_len: 8'd3, exp_size: 3'd2};
        vecs[1] = '{dsel: 1'b1, typ: 3'b000, addr: 32'h0000_0013, exp_id: 4'd1,
                    exp_len: 8'd0, exp_size: 3'd0};
        vecs[2] = '{dsel: 1'b1, typ: 3'b001, addr: 32'h0000_0022, exp_id: 4'd1,
                    exp_len: 8'd0, exp_size: 3'd1};
        vecs[3] = '{dsel: 1'b0, typ: 3'b010, addr: 32'h1C00_0104, exp_id: 4'd0,
                    exp_len: 8'd0, exp_size: 3'd2};
        vecs[4] = '{dsel: 1'b1, typ: 3'b100, addr: 32'h0000_1230, exp_id: 4'd1,
                    exp_len: 8'd3, exp_size: 3'd2};

        resetn = 1'b0;
        i_rd_req = 0; i_rd_type = 0; i_rd_addr = 0;
        d_rd_req = 0; d_rd_type = 0; d_rd_addr = 0;
        d_wr_req = 0; d_wr_type = 0; d_wr_addr = 0; d_wr_wstrb = 0; d_wr_data = 0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

        // Reset state
        smp();
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_rready", rready, 1'b0);
        check("rst_bready", bready, 1'b0);
        check("rst_araddr", araddr, 32'd0);
        tick(); resetn = 1'b1;
        smp();
        check("rst_d_wr_rdy", d_wr_rdy, 1'b1);
        check("rst_d_rd_rdy", d_rd_rdy, 1'b1);
        check("rst_i_rd_rdy", i_rd_rdy, 1'b1);

        // Read encodings, one client at a time
        for (int v = 0; v < 5; v++) begin
            rd_req(vecs[v].dsel, vecs[v].typ, vecs[v].addr);
            check("arvalid", arvalid, 1'b1);
            check("arid", arid, vecs[v].exp_id);
            check("araddr", araddr, vecs[v].addr);
            check("arlen", arlen, vecs[v].exp_len);
            check("arsize", arsize, vecs[v].exp_size);
            check("arburst", arburst, 2'b01);
            check("rdy_busy", vecs[v].dsel ? d_rd_rdy : i_rd_rdy, 1'b0);
            ar_hs();
            smp();
            check("arvalid_drop", arvalid, 1'b0);
            check("rready", rready, 1'b1);
            rd_beats(vecs[v].exp_id, int'(vecs[v].exp_len) + 1, 32'hA000_0000 + 32'(v << 8),
                     vecs[v].dsel);
            smp();
            check("rdy_after_rlast", vecs[v].dsel ? d_rd_rdy : i_rd_rdy, 1'b1);
            check("rready_off", rready, 1'b0);
        end

        // Simultaneous i/d line reads: dcache first
        tick();
        d_rd_req = 1'b1; d_rd_type = 3'b100; d_rd_addr = 32'h0000_3000;
        i_rd_req = 1'b1; i_rd_type = 3'b100; i_rd_addr = 32'h1C00_0200;
        smp();
        check("sim_d_rdy", d_rd_rdy, 1'b1);
        check("sim_i_rdy", i_rd_rdy, 1'b0);
        tick(); d_rd_req = 1'b0;
        smp();
        check("sim_arid_d", arid, 4'd1);
        check("sim_araddr_d", araddr, 32'h0000_3000);
        ar_hs();
        rd_beats(4'd1, 4, 32'hD000_0000, 1'b1);
        smp();
        check("sim_i_rdy_after", i_rd_rdy, 1'b1);
        tick(); i_rd_req = 1'b0;
        smp();
        check("sim_arid_i", arid, 4'd0);
        check("sim_araddr_i", araddr, 32'h1C00_0200);
        ar_hs();
        rd_beats(4'd0, 4, 32'hC000_0000, 1'b0);

        // Line writeback with wready stalled on beat 1
        wr_issue(3'b100, 32'h0000_0040, 4'h0,
                 128'h4444_4444_3333_3333_2222_2222_1111_1111);
        aw_hs();
        w_run(0, 2, 4);
        b_phase(1'b0);

        // Uncached word write
        wr_issue(3'b010, 32'hBFAF_8000, 4'b0011, {96'h0, 32'hCAFE_F00D});
        aw_hs();
        w_run(0, 0, 1);
        b_phase(1'b0);

        // Hazard: dcache read to the pending write's line waits; icache read proceeds
        wr_issue(3'b100, 32'h0000_0080, 4'h0,
                 128'h8888_0004_8888_0003_8888_0002_8888_0001);
        tick();
        d_rd_req = 1'b1; d_rd_type = 3'b010; d_rd_addr = 32'h0000_0084;
        i_rd_req = 1'b1; i_rd_type = 3'b100; i_rd_addr = 32'h0000_0200;
        smp();
        check("hz_d_rdy", d_rd_rdy, 1'b0);
        check("hz_i_rdy", i_rd_rdy, 1'b1);
        tick(); i_rd_req = 1'b0;
        smp();
        check("hz_arid", arid, 4'd0);
        check("hz_araddr", araddr, 32'h0000_0200);
        ar_hs();
        rd_beats(4'd0, 4, 32'hB000_0000, 1'b0);
        smp();
        check("hz_hold_idle", d_rd_rdy, 1'b0);
        aw_hs();
        w_run(0, 0, 4);
        b_phase(1'b1);
        tick(); d_rd_req = 1'b0;
        smp();
        check("hz_d_arvalid", arvalid, 1'b1);
        check("hz_d_arid", arid, 4'd1);
        check("hz_d_araddr", araddr, 32'h0000_0084);
        ar_hs();
        rd_beats(4'd1, 1, 32'hE000_0000, 1'b1);

        // Reset during beat 2 of a read burst, with a write parked in AW
        wr_issue(3'b010, 32'h0000_0100, 4'hf, 128'h1234);
        rd_req(1'b1, 3'b100, 32'h0000_5000);
        ar_hs();
        begin
            rexp_t e;
            tick();
            rvalid = 1'b1; rid = 4'd1; rdata = 32'h5500_0000; rlast = 1'b0;
            e.dsel = 1'b1; e.data = 32'h5500_0000; e.last = 1'b0;
            rq.push_back(e);
        end
        tick(); rvalid = 1'b0;
        tick(); rvalid = 1'b1; rdata = 32'h5500_0001; resetn = 1'b0;
        smp();
        check("rstm_arvalid", arvalid, 1'b0);
        check("rstm_rready", rready, 1'b0);
        check("rstm_awvalid", awvalid, 1'b0);
        check("rstm_d_ret", d_ret_valid, 1'b0);
        tick(); resetn = 1'b1; rdata = 32'h5500_0002;
        smp();
        check("rstm_d_ret_after", d_ret_valid, 1'b0);
        check("rstm_d_rdy", d_rd_rdy, 1'b1);
        check("rstm_i_rdy", i_rd_rdy, 1'b1);
        check("rstm_wr_rdy", d_wr_rdy, 1'b1);
        tick(); rvalid = 1'b0;
        wq.delete();
        smp();

        check("rq_empty", rq.size(), 0);
        check("wq_empty", wq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
